pcm_i2s_tx: RTL and testbench
=============================

# pcm_i2s_tx

Stereo I2S serializer downstream of the left/right `cic` decimators. It captures each pair of 16-bit PCM words on the rising edge of the `clk_pcm` strobe from `audio_clock`. It then shifts the pair out MSB-first as standard I2S (`bclk`, `lrclk`, `sdata`) to an external codec, with one-sample buffering and sticky overrun/underrun flags.

## Interface

Parameters:
- `WIDTH`, 16, bits per channel word; frame length is 2*WIDTH bclk periods.
- `BCLK_DIV`, 4, `clk` cycles per bclk half-period (≥1).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `pcm_stb`  in  1  `clk_pcm` from `audio_clock`; a new sample pair is taken on its rising edge.
- `left`  in  WIDTH  left PCM word (`val[0]`), two's complement.
- `right`  in  WIDTH  right PCM word (`val[1]`), two's complement.
- `clr_flags`  in  1  one-cycle pulse; clears `overrun` and `underrun`.
- `bclk`  out  1  I2S bit clock.
- `lrclk`  out  1  word select; 0 = left, 1 = right.
- `sdata`  out  1  serial data.
- `overrun`  out  1  sticky; a pair arrived while the previous pair was still pending.
- `underrun`  out  1  sticky; a frame started with no pending pair after the first capture.

## Operation

- `pcm_stb` passes through a 2-flop synchronizer and a rising-edge detector, giving `stb_rise`.
- `left` and `right` are sampled in the same `clk` cycle as `stb_rise`, which is 3 cycles after the raw edge. The CIC outputs are stable across `clk_pcm` high.
- Pending register: `pend_l`, `pend_r`, `pend_v`.
  - On `stb_rise`, load both words and set `pend_v`.
  - If `pend_v` is already 1 and the register is not being consumed in the same cycle, set `overrun`; the new data overwrites the old.
- The divider counts 0..BCLK_DIV-1 and toggles `bclk` on wrap.
- The bit counter `bitcnt` runs 0..2*WIDTH-1 and advances on each bclk falling edge.
- Frame start is the bclk falling edge where `bitcnt` wraps to 0:
  - `pend_v`=1: load the 2*WIDTH-bit shifter with {pend_l, pend_r} and clear `pend_v`.
    - Consuming and `stb_rise` in the same cycle: the new pair is captured, `pend_v` stays 1, and no overrun is flagged.
  - `pend_v`=0 and `primed`=1: load zeros and set `underrun`.
  - `pend_v`=0 and `primed`=0: load zeros; no flag.
  - `primed` is set by the first `stb_rise` after reset.
- `lrclk` is 0 for `bitcnt` 0..WIDTH-1 and 1 for WIDTH..2*WIDTH-1. It changes on the bclk falling edge.
- I2S one-bit delay:
  - `sdata` presents shifter bit [2*WIDTH-1] starting one bclk after each `lrclk` transition.
  - The last bit of each word overlaps the first bclk of the next `lrclk` phase.
- `clr_flags` takes priority over a set event in the same cycle.

## Timing

- Reset values: `bclk`=0, `lrclk`=1, `sdata`=0, `overrun`=0, `underrun`=0. All counters, `pend_v` and `primed` are 0; the shifter is 0.
- First bclk rising edge: BCLK_DIV cycles after reset release.
- First bclk falling edge: 2*BCLK_DIV cycles after reset release.
  - This is the first frame start; `lrclk` goes to 0.
  - `sdata` carries the left MSB from the next falling edge.
- All outputs are registered and change only on `clk` rising edges. `sdata` and `lrclk` change in the same `clk` cycle as the bclk falling edge.
- Frame period: 4*WIDTH*BCLK_DIV `clk` cycles, i.e. 256 at defaults.
- Latency: the word captured at `stb_rise` appears at the first frame start after that cycle.
  - Its MSB is on `sdata` one bclk period later.
- Reset mid-frame aborts immediately; outputs return to reset values asynchronously.

## Structure

- Package `audio_pkg` holds:
  - `PCM_WIDTH` (16);
  - `I2S_BCLK_DIV` default;
  - type `pcm_t` = logic [PCM_WIDTH-1:0].
- Sub-module `strobe_sync`: 2-flop synchronizer plus rising-edge pulse, with async active-low reset. It is reusable for the `clk_left` and `clk_right` strobes.
- The remainder is a single always-block datapath with counters, the pending register and the shifter.

## Test plan

- Reset release with `pcm_stb` held low:
  - `lrclk` goes 1→0 at cycle 8 (BCLK_DIV=4).
  - `sdata` stays 0.
  - `underrun` stays 0 indefinitely.
- Pulse `pcm_stb` with left=16'hA5C3, right=16'h8001 before frame start:
  - The next frame shifts 1010_0101_1100_0011 in the `lrclk`=0 window, delayed one bclk.
  - It then shifts 1000_0000_0000_0001 in the `lrclk`=1 window.
- After one captured pair, hold off `pcm_stb` for two frames:
  - `underrun` sets at the second frame start.
  - Zeros are shifted.
  - `clr_flags` clears it the next cycle.
- Two `pcm_stb` edges within one frame (left=16'h0001, then 16'h7FFF):
  - `overrun`=1.
  - The next frame carries 16'h7FFF.
- `stb_rise` in the exact cycle of frame-start consumption:
  - No overrun.
  - The new pair is transmitted in the following frame.
- Assert reset mid-frame (`bitcnt`≈20):
  - Outputs return to reset values in the same cycle.
  - After release, the frame timing repeats as in the first scenario.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path constants and the PCM word type used by the decimators and the I2S transmitter.
package audio_pkg;
  localparam int PCM_WIDTH    = 16;
  localparam int I2S_BCLK_DIV = 4;

  typedef logic [PCM_WIDTH-1:0] pcm_t;
endpackage

// File: rtl/strobe_sync.sv
// Two-flop synchronizer for a slow strobe plus a single-cycle rising-edge pulse.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_i,
  output logic rise_o
);
  // [0],[1] synchronize; [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], strobe_i};
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/pcm_i2s_tx.sv
// Stereo I2S serializer: one-pair pending buffer, bclk/lrclk generation, MSB-first shifter, sticky flags.
module pcm_i2s_tx
  import audio_pkg::*;
#(
  parameter int WIDTH    = PCM_WIDTH,
  parameter int BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcm_stb,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             clr_flags,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             overrun,
  output logic             underrun
);
  localparam int FRAME = 2 * WIDTH;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] l;
    logic [WIDTH-1:0] r;
  } pair_t;

  logic             stb_rise;
  logic             wrap, fall, fstart, consume;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             bclk_q, bclk_d;
  logic             run_q, run_d;
  logic             lr_q, lr_d;
  logic             sd_q, sd_d;
  logic [FRAME-1:0] shift_q, shift_d;
  pair_t            pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             primed_q, primed_d;
  logic             ovr_q, ovr_d;
  logic             und_q, und_d;

  strobe_sync u_stb (
    .clk     (clk),
    .rst_n   (reset),
    .strobe_i(pcm_stb),
    .rise_o  (stb_rise)
  );

  assign wrap    = (div_q == DW'(BCLK_DIV - 1));
  assign fall    = wrap & bclk_q;
  // run_q is clear only before the very first falling edge, which starts the first frame
  assign fstart  = fall & (~run_q | (bitcnt_q == BW'(FRAME - 1)));
  assign consume = fstart & pend_v_q;

  always_comb begin
    div_d    = wrap ? '0 : div_q + DW'(1);
    bclk_d   = wrap ? ~bclk_q : bclk_q;
    bitcnt_d = bitcnt_q;
    run_d    = run_q;
    lr_d     = lr_q;
    sd_d     = sd_q;
    shift_d  = shift_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    primed_d = primed_q;

    if (fall) begin
      run_d    = 1'b1;
      bitcnt_d = fstart ? '0 : bitcnt_q + BW'(1);
      lr_d     = (bitcnt_d >= BW'(WIDTH));
      // sdata lags the shifter by one bclk, which yields the I2S one-bit delay
      sd_d     = shift_q[FRAME-1];
      shift_d  = {shift_q[FRAME-2:0], 1'b0};
    end
    if (fstart) shift_d = consume ? {pend_q.l, pend_q.r} : '0;

    if (stb_rise) begin
      pend_d.l = left;
      pend_d.r = right;
      pend_v_d = 1'b1;
      primed_d = 1'b1;
    end else if (consume) begin
      pend_v_d = 1'b0;
    end

    ovr_d = clr_flags ? 1'b0 : (ovr_q | (stb_rise & pend_v_q & ~consume));
    und_d = clr_flags ? 1'b0 : (und_q | (fstart & ~pend_v_q & primed_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      bitcnt_q <= '0;
      run_q    <= 1'b0;
      lr_q     <= 1'b1;
      sd_q     <= 1'b0;
      shift_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      primed_q <= 1'b0;
      ovr_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      bitcnt_q <= bitcnt_d;
      run_q    <= run_d;
      lr_q     <= lr_d;
      sd_q     <= sd_d;
      shift_q  <= shift_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      primed_q <= primed_d;
      ovr_q    <= ovr_d;
      und_q    <= und_d;
    end
  end

  assign bclk     = bclk_q;
  assign lrclk    = lr_q;
  assign sdata    = sd_q;
  assign overrun  = ovr_q;
  assign underrun = und_q;
endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Bench for pcm_i2s_tx: frame-aligned stimulus, I2S receiver model feeding a word scoreboard.
`timescale 1ns/1ps
module tb_pcm_i2s_tx;
  import audio_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic pcm_stb = 1'b0;
  pcm_t left = '0, right = '0;
  logic clr_flags = 1'b0;
  logic bclk, lrclk, sdata, overrun, underrun;

  int checks = 0;
  int failures = 0;
  int cyc;
  pcm_t exp_q[$];

  typedef struct {
    pcm_t l1, r1;
    bit   dbl;
    pcm_t l2, r2;
    pcm_t exp_l, exp_r;
    bit   exp_ovr;
  } vec_t;
  vec_t tbl[4];

  pcm_i2s_tx dut (
    .clk(clk), .reset(reset), .pcm_stb(pcm_stb), .left(left), .right(right),
    .clr_flags(clr_flags), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // cyc == n after the n-th rising edge following reset release
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int fs(int k);
    return 8 + 256 * k;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  // strobe is raised so that stb_rise samples the words at edge c
  task automatic strobe_at(int c, pcm_t l, pcm_t r);
    wait_cyc(c - 3);
    pcm_stb = 1'b1;
    left    = l;
    right   = r;
    wait_cyc(c + 2);
    pcm_stb = 1'b0;
  endtask

  task automatic pulse_clr(int n);
    wait_cyc(n);
    clr_flags = 1'b1;
    wait_cyc(n + 1);
    clr_flags = 1'b0;
    chk("clr_overrun", {31'b0, overrun}, 32'd0);
    chk("clr_underrun", {31'b0, underrun}, 32'd0);
  endtask

  task automatic push_pair(pcm_t l, pcm_t r);
    exp_q.push_back(l);
    exp_q.push_back(r);
  endtask

  // Codec-side receiver: samples on bclk rise, a word ends where lrclk changes
  task automatic monitor();
    logic pb, plr;
    pcm_t sh, e;
    int   nb;
    pb = 1'b0; plr = 1'b1; sh = '0; nb = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pb = 1'b0; plr = 1'b1; nb = 0;
      end else begin
        if (bclk && !pb) begin
          sh = {sh[PCM_WIDTH-2:0], sdata};
          nb++;
          if (lrclk != plr) begin
            if (nb == PCM_WIDTH) begin
              if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_word at cyc=%0d actual=%h required=none", cyc, sh);
              end else begin
                e = exp_q.pop_front();
                chk(plr ? "word_right" : "word_left", {16'b0, sh}, {16'b0, e});
              end
            end
            nb  = 0;
            plr = lrclk;
          end
        end
        pb = bclk;
      end
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_bclk"}, {31'b0, bclk}, 32'd0);
    chk({tag, "_lrclk"}, {31'b0, lrclk}, 32'd1);
    chk({tag, "_sdata"}, {31'b0, sdata}, 32'd0);
    chk({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    chk({tag, "_underrun"}, {31'b0, underrun}, 32'd0);
  endtask

  task automatic chk_start_timing();
    wait_cyc(3); chk("bclk_pre_rise", {31'b0, bclk}, 32'd0);
    wait_cyc(4); chk("bclk_first_rise", {31'b0, bclk}, 32'd1);
    wait_cyc(7); chk("lrclk_pre_start", {31'b0, lrclk}, 32'd1);
    wait_cyc(8); chk("lrclk_first_start", {31'b0, lrclk}, 32'd0);
                 chk("bclk_first_fall", {31'b0, bclk}, 32'd0);
    wait_cyc(16); chk("sdata_idle", {31'b0, sdata}, 32'd0);
    wait_cyc(270); chk("no_underrun_unprimed", {31'b0, underrun}, 32'd0);
  endtask

  initial begin
    int base;
    tbl[0] = '{16'h0000, 16'h0000, 1'b0, 16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC, 1'b0};
    tbl[1] = '{16'h0001, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b0, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 1'b0};

    fork monitor(); join_none

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    push_pair('0, '0);
    push_pair('0, '0);
    reset = 1'b1;
    chk_start_timing();

    // first pair, captured mid frame 1, shown in frame 2 one bclk after lrclk falls
    strobe_at(300, 16'hA5C3, 16'h8001);
    push_pair(16'hA5C3, 16'h8001);
    wait_cyc(fs(2) - 1); chk("lrclk_f2_pre", {31'b0, lrclk}, 32'd1);
    wait_cyc(fs(2));     chk("lrclk_f2", {31'b0, lrclk}, 32'd0);
    wait_cyc(fs(2) + 7); chk("sdata_delay_pre", {31'b0, sdata}, 32'd0);
    wait_cyc(fs(2) + 8); chk("sdata_left_msb", {31'b0, sdata}, 32'd1);

    // starvation: frame 3 has nothing pending
    push_pair('0, '0);
    wait_cyc(fs(3) - 1); chk("underrun_pre", {31'b0, underrun}, 32'd0);
    wait_cyc(fs(3));     chk("underrun_set", {31'b0, underrun}, 32'd1);
    pulse_clr(fs(3) + 4);

    for (int i = 0; i < 4; i++) begin
      base = fs(3 + i);
      if (tbl[i].dbl) begin
        strobe_at(base + 40, tbl[i].l1, tbl[i].r1);
        strobe_at(base + 120, tbl[i].l2, tbl[i].r2);
      end else begin
        strobe_at(base + 60, tbl[i].l2, tbl[i].r2);
      end
      push_pair(tbl[i].exp_l, tbl[i].exp_r);
      wait_cyc(base + 200);
      chk($sformatf("vec%0d_overrun", i), {31'b0, overrun}, {31'b0, tbl[i].exp_ovr});
      chk($sformatf("vec%0d_underrun", i), {31'b0, underrun}, 32'd0);
      pulse_clr(base + 210);
    end

    // capture lands on the very edge that consumes the pending pair
    strobe_at(fs(7) + 60, 16'h5A5A, 16'hC3C3);
    push_pair(16'h5A5A, 16'hC3C3);
    strobe_at(fs(8), 16'h1111, 16'h2222);
    push_pair(16'h1111, 16'h2222);
    exp_q.push_back('0);
    wait_cyc(fs(8) + 4); chk("coincident_no_overrun", {31'b0, overrun}, 32'd0);

    // reset in frame 10 around bitcnt 20, after its zero left word is out
    wait_cyc(fs(10) + 160);
    chk("underrun_before_reset", {31'b0, underrun}, 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_vals("midreset");
    repeat (3) @(negedge clk);
    chk("queue_drained_at_reset", exp_q.size(), 32'd0);
    push_pair('0, '0);
    reset = 1'b1;
    chk_start_timing();
    wait_cyc(300);
    chk("queue_drained_end", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
